// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: opcode constants, the
// memory-control FSM state type and the default datapath widths. Used by the
// memory control unit, the ULA and the RAM models.
package proc_pkg;

  // Default widths
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_OPC_W   = 4;
  localparam int DEF_OPND_W  = 4;
  localparam int DEF_MEM_LAT = 1;

  // Width of the read-latency down-counter (covers MEM_LAT 1..15)
  localparam int LAT_CNT_W = 4;

  // Memory-access opcodes; every other value is a NOP/ULA instruction
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_LOADI = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD_RD,
    ST_LOAD_WAIT,
    ST_DONE
  } uc_state_t;

endpackage

// File: rtl/unidade_controle_mem.sv
// Memory-access control unit. Accepts one decoded instruction per
// valid/ready handshake and sequences a RAM store, a RAM load with a
// configurable read latency, an immediate load, or a no-op, then pulses done.
//
// Ports:
//   clock, reset_n      single clock, asynchronous active-low reset
//   enable              0 freezes FSM, latency counter and all registers
//   instr_valid/ready   instruction handshake (ready = unit idle)
//   opcode, operando    instruction; operando is RAM address or immediate
//   reg_saida_ula       store data source (ULA result register)
//   rd, we              registered RAM read / write strobes
//   end_mem             RAM address
//   data_in_mem         RAM write data
//   data_out_mem        RAM read data
//   reg_saida_mem       loaded value towards register A
//   done                one-cycle retire pulse
module unidade_controle_mem
  import proc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int OPND_W  = DEF_OPND_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [OPND_W-1:0] operando,
  input  logic [DATA_W-1:0] reg_saida_ula,
  output logic              rd,
  output logic              we,
  output logic [ADDR_W-1:0] end_mem,
  output logic [DATA_W-1:0] data_in_mem,
  input  logic [DATA_W-1:0] data_out_mem,
  output logic [DATA_W-1:0] reg_saida_mem,
  output logic              done
);

  if (ADDR_W != OPND_W) begin : g_chk_addr
    $error("unidade_controle_mem: ADDR_W must equal OPND_W");
  end
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_chk_lat
    $error("unidade_controle_mem: MEM_LAT must be in 1..15");
  end

  localparam logic [OPC_W-1:0]     OPC_STORE = OPC_W'(OP_STORE);
  localparam logic [OPC_W-1:0]     OPC_LOAD  = OPC_W'(OP_LOAD);
  localparam logic [OPC_W-1:0]     OPC_LOADI = OPC_W'(OP_LOADI);
  localparam logic [LAT_CNT_W-1:0] LAT       = LAT_CNT_W'(MEM_LAT);

  uc_state_t            state;
  uc_state_t            state_next;
  logic [LAT_CNT_W-1:0] lat_cnt;

  logic accept;
  logic is_store;
  logic is_load;
  logic is_loadi;
  logic lat_last;

  logic rd_next;
  logic we_next;
  logic done_next;
  logic ready_next;

  // Instruction decode and handshake
  always_comb begin
    is_store = (opcode == OPC_STORE);
    is_load  = (opcode == OPC_LOAD);
    is_loadi = (opcode == OPC_LOADI);
    accept   = enable & instr_valid & (state == ST_IDLE);
    lat_last = (lat_cnt <= LAT_CNT_W'(1));
  end

  // Next-state logic; enable low keeps the current state
  always_comb begin
    state_next = state;
    if (enable) begin
      unique case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (is_store)     state_next = ST_STORE;
            else if (is_load) state_next = ST_LOAD_RD;
            else              state_next = ST_DONE;
          end
        end
        ST_STORE:     state_next = ST_DONE;
        ST_LOAD_RD:   state_next = ST_LOAD_WAIT;
        ST_LOAD_WAIT: if (lat_last) state_next = ST_DONE;
        ST_DONE:      state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so the strobes
  // and done come straight from flops and are aligned with the state they
  // belong to. A frozen state naturally holds (stretches) them.
  always_comb begin
    rd_next    = (state_next == ST_LOAD_RD);
    we_next    = (state_next == ST_STORE);
    done_next  = (state_next == ST_DONE);
    ready_next = (state_next == ST_IDLE);
  end

  // State and control-output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rd          <= 1'b0;
      we          <= 1'b0;
      done        <= 1'b0;
      instr_ready <= 1'b1;
    end else if (enable) begin
      state       <= state_next;
      rd          <= rd_next;
      we          <= we_next;
      done        <= done_next;
      instr_ready <= ready_next;
    end
  end

  // Datapath registers and read-latency counter. The operand is captured
  // directly into end_mem for memory opcodes, so end_mem holds its value
  // after the access; LOADI/NOP leave it untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      end_mem       <= '0;
      data_in_mem   <= '0;
      reg_saida_mem <= '0;
      lat_cnt       <= '0;
    end else if (enable) begin
      if (accept && (is_store || is_load)) begin
        end_mem <= ADDR_W'(operando);
      end
      if (accept && is_store) begin
        data_in_mem <= reg_saida_ula;
      end
      if (accept && is_loadi) begin
        reg_saida_mem <= DATA_W'(operando);
      end
      if (state == ST_LOAD_RD) begin
        lat_cnt <= LAT;
      end else if (state == ST_LOAD_WAIT) begin
        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
        if (lat_last) begin
          reg_saida_mem <= data_out_mem;
        end
      end
    end
  end

endmodule

// File: tb/tb_unidade_controle_mem.sv
// Scoreboard bench for unidade_controle_mem. Two instances: index 0 with
// MEM_LAT=1, index 1 with MEM_LAT=3, each with its own RAM model whose read
// data is junk until the programmed latency has elapsed after rd.
module tb_unidade_controle_mem;
  import proc_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rstn   [2];
  logic       en     [2];
  logic       vld    [2];
  logic [3:0] opc    [2];
  logic [3:0] opnd   [2];
  logic [7:0] ula    [2];
  logic       rdy    [2];
  logic       rd_o   [2];
  logic       we_o   [2];
  logic [3:0] addr_o [2];
  logic [7:0] din_o  [2];
  logic [7:0] dout   [2];
  logic [7:0] rsm    [2];
  logic       done_o [2];

  unidade_controle_mem #(
    .DATA_W(8), .ADDR_W(4), .OPC_W(4), .OPND_W(4), .MEM_LAT(1)
  ) u_lat1 (
    .clock(clock), .reset_n(rstn[0]), .enable(en[0]),
    .instr_valid(vld[0]), .instr_ready(rdy[0]),
    .opcode(opc[0]), .operando(opnd[0]), .reg_saida_ula(ula[0]),
    .rd(rd_o[0]), .we(we_o[0]), .end_mem(addr_o[0]),
    .data_in_mem(din_o[0]), .data_out_mem(dout[0]),
    .reg_saida_mem(rsm[0]), .done(done_o[0])
  );

  unidade_controle_mem #(
    .DATA_W(8), .ADDR_W(4), .OPC_W(4), .OPND_W(4), .MEM_LAT(3)
  ) u_lat3 (
    .clock(clock), .reset_n(rstn[1]), .enable(en[1]),
    .instr_valid(vld[1]), .instr_ready(rdy[1]),
    .opcode(opc[1]), .operando(opnd[1]), .reg_saida_ula(ula[1]),
    .rd(rd_o[1]), .we(we_o[1]), .end_mem(addr_o[1]),
    .data_in_mem(din_o[1]), .data_out_mem(dout[1]),
    .reg_saida_mem(rsm[1]), .done(done_o[1])
  );

  // RAM models
  logic [7:0] ram [2][16];
  int         pend [2];
  logic [3:0] pa   [2];

  always @(posedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (!rstn[u]) begin
        ram[u][3] <= 8'h3C;
        ram[u][5] <= 8'h5A;
        pend[u]   <= 0;
      end else begin
        if (we_o[u]) ram[u][addr_o[u]] <= din_o[u];
        if (rd_o[u]) begin
          pend[u] <= (u == 0) ? 1 : 3;
          pa[u]   <= addr_o[u];
        end else if (pend[u] > 1) begin
          pend[u] <= pend[u] - 1;
        end
      end
    end
  end

  assign dout[0] = (pend[0] == 1) ? ram[0][pa[0]] : 8'hEE;
  assign dout[1] = (pend[1] == 1) ? ram[1][pa[1]] : 8'hEE;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         u;
    int         cyc;
    logic [7:0] mem;
  } done_t;

  typedef struct {
    int         u;
    int         cyc;
    logic       we;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } strb_t;

  done_t qd[$];
  strb_t qs[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one instruction, wait (bounded) for acceptance, push expectations.
  // Returns in cycle T+1, 1ns after its rising edge.
  task automatic issue(input int u, input logic [3:0] op, input logic [3:0] od,
                       input logic [7:0] uv, input int done_off,
                       input logic [7:0] exp_mem, input bit track, output int t);
    bit    acc;
    done_t d;
    strb_t s;
    acc = 0;
    t   = -1;
    @(posedge clock); #1;
    opc[u] = op; opnd[u] = od; ula[u] = uv; vld[u] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (rdy[u] === 1'b1 && en[u] === 1'b1) begin
        acc = 1;
        t   = cyc;
        break;
      end
    end
    if (!acc) begin
      chk("accept_timeout", {31'd0, rdy[u]}, 32'd1);
    end else if (track) begin
      d.u = u; d.cyc = t + done_off; d.mem = exp_mem;
      qd.push_back(d);
      if (op == OP_STORE || op == OP_LOAD) begin
        s.u = u; s.cyc = t + 1; s.we = (op == OP_STORE); s.rd = (op == OP_LOAD);
        s.addr = od; s.data = uv;
        qs.push_back(s);
      end
    end
    @(posedge clock); #1;
    vld[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (rdy[u] === 1'b1 && qd.size() == 0 && qs.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout_pending", qd.size(), 32'd0);
  endtask

  task automatic chk_reset(input int u);
    chk("rst_rd",   {31'd0, rd_o[u]},   32'd0);
    chk("rst_we",   {31'd0, we_o[u]},   32'd0);
    chk("rst_done", {31'd0, done_o[u]}, 32'd0);
    chk("rst_rdy",  {31'd0, rdy[u]},    32'd1);
    chk("rst_end_mem",       {28'd0, addr_o[u]}, 32'd0);
    chk("rst_data_in_mem",   {24'd0, din_o[u]},  32'd0);
    chk("rst_reg_saida_mem", {24'd0, rsm[u]},    32'd0);
  endtask

  initial begin
    int    t;
    int    t2;
    done_t de;
    strb_t se;

    for (int u = 0; u < 2; u++) begin
      rstn[u] = 1'b0; en[u] = 1'b1; vld[u] = 1'b0;
      opc[u] = '0; opnd[u] = '0; ula[u] = '0;
    end

    // Monitor: pops expectations whenever a unit shows done or a strobe
    fork
      forever begin
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
          if (rstn[u] === 1'b1 && done_o[u] === 1'b1) begin
            if (qd.size() == 0) begin
              chk("spurious_done", {31'd0, done_o[u]}, 32'd0);
            end else begin
              de = qd.pop_front();
              chk("done_unit", u, de.u);
              chk("done_cycle", cyc, de.cyc);
              chk("reg_saida_mem", {24'd0, rsm[u]}, {24'd0, de.mem});
            end
          end
          if (rstn[u] === 1'b1 && (rd_o[u] === 1'b1 || we_o[u] === 1'b1)) begin
            if (qs.size() == 0) begin
              chk("spurious_strobe", {30'd0, rd_o[u], we_o[u]}, 32'd0);
            end else begin
              se = qs.pop_front();
              chk("strobe_unit", u, se.u);
              chk("strobe_cycle", cyc, se.cyc);
              chk("strobe_we", {31'd0, we_o[u]}, {31'd0, se.we});
              chk("strobe_rd", {31'd0, rd_o[u]}, {31'd0, se.rd});
              chk("end_mem", {28'd0, addr_o[u]}, {28'd0, se.addr});
              if (se.we) chk("data_in_mem", {24'd0, din_o[u]}, {24'd0, se.data});
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clock);
    #1;
    chk_reset(0);
    chk_reset(1);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    // STORE 5 <- A7: we in T+1, done in T+2
    issue(0, OP_STORE, 4'h5, 8'hA7, 2, 8'h00, 1, t);
    wait_idle(0);

    // LOAD 3, MEM_LAT=1: done with 3C in T+3
    issue(0, OP_LOAD, 4'h3, 8'h00, 3, 8'h3C, 1, t);
    wait_idle(0);

    // LOADI 9: done with 09 in T+1
    issue(0, OP_LOADI, 4'h9, 8'h00, 1, 8'h09, 1, t);
    wait_idle(0);

    // LOAD 3, MEM_LAT=3: done with 3C in T+5
    issue(1, OP_LOAD, 4'h3, 8'h00, 5, 8'h3C, 1, t);
    wait_idle(1);

    // LOAD 5, MEM_LAT=3, enable low in T+3 and T+4: done in T+7.
    // A STORE is held on instr_valid while busy and must not be taken.
    issue(1, OP_LOAD, 4'h5, 8'h00, 7, 8'h5A, 1, t);
    opc[1] = OP_STORE; opnd[1] = 4'h1; ula[1] = 8'hFF; vld[1] = 1'b1;
    @(negedge clock);
    chk("busy_not_ready", {31'd0, rdy[1]}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    en[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    en[1] = 1'b1;
    vld[1] = 1'b0;
    wait_idle(1);

    // NOP then STORE back-to-back: NOP done in T+1, STORE accepted in T+2
    issue(0, 4'b0010, 4'h0, 8'hFF, 1, 8'h09, 1, t);
    issue(0, OP_STORE, 4'hA, 8'h3E, 2, 8'h09, 1, t2);
    chk("b2b_accept_cycle", t2, t + 2);
    wait_idle(0);

    // Read back the stored word
    issue(0, OP_LOAD, 4'hA, 8'h00, 3, 8'h3E, 1, t);
    wait_idle(0);

    // Reset during STORE: strobe drops without a clock edge
    issue(0, OP_STORE, 4'h7, 8'h11, 2, 8'h00, 0, t);
    chk("we_before_reset", {31'd0, we_o[0]}, 32'd1);
    #2;
    rstn[0] = 1'b0;
    #1;
    chk_reset(0);
    @(posedge clock); #1;
    rstn[0] = 1'b1;
    repeat (5) @(posedge clock);

    @(negedge clock);
    chk("done_queue_empty", qd.size(), 32'd0);
    chk("strobe_queue_empty", qs.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle_mem.md
# unidade_controle_mem

Parametrised memory-access control unit for the simple processor. It accepts one decoded instruction (opcode + operand) per handshake and sequences RAM store/load cycles with a configurable memory read latency. It also handles immediate loads, and signals completion with a `done` pulse. It sits between the instruction decoder, the ULA output register and the data RAM, and replaces the combinational store/load decode with a registered FSM.

## Interface
- `DATA_W`, default 8: data path width (RAM word, ULA result, `reg_saida_mem`).
- `ADDR_W`, default 4: RAM address width; must equal `OPND_W`.
- `OPC_W`, default 4: opcode width.
- `OPND_W`, default 4: operand width.
- `MEM_LAT`, default 1: RAM read latency in cycles, from `rd` high to `data_out_mem` valid; legal range 1..15.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 0 freezes the FSM, latency counter and all registers.
- `instr_valid` in 1: instruction present on `opcode`/`operando`.
- `instr_ready` out 1: unit is idle and accepts an instruction.
- `opcode` in OPC_W: instruction opcode.
- `operando` in OPND_W: RAM address, or immediate for LOADI.
- `reg_saida_ula` in DATA_W: ULA result register, the store data source.
- `rd` out 1: RAM read strobe.
- `we` out 1: RAM write strobe.
- `end_mem` out ADDR_W: RAM address.
- `data_in_mem` out DATA_W: RAM write data.
- `data_out_mem` in DATA_W: RAM read data.
- `reg_saida_mem` out DATA_W: loaded value, towards register A.
- `done` out 1: one-cycle pulse when an instruction retires.

## Operation
- Opcodes: STORE = 4'b1100, LOAD = 4'b1101, LOADI = 4'b1110. Any other opcode is NOP/ULA: the unit accepts it, performs no memory access and pulses `done`.
- Acceptance happens in cycle T when `instr_valid & instr_ready & enable`. At that edge the unit captures `opcode` and `operando`, and also captures `reg_saida_ula` when the opcode is STORE.
- FSM states:
  - IDLE: `instr_ready`=1. On accept, go to STORE, LOAD_RD or DONE according to the opcode.
  - STORE: `we`=1, `end_mem`=operand, `data_in_mem`=captured ULA value. Next state is DONE.
  - LOAD_RD: `rd`=1, `end_mem`=operand. The latency counter loads MEM_LAT. Next state is LOAD_WAIT.
  - LOAD_WAIT: the counter decrements each enabled cycle. When the counter reaches 1, `data_out_mem` is registered into `reg_saida_mem` and the next state is DONE.
  - DONE: `done`=1. Next state is IDLE.
- LOADI: `reg_saida_mem` takes the operand zero-extended to DATA_W at the accept edge. The next state is DONE.
- `rd` and `we` are registered, mutually exclusive and never high outside STORE/LOAD_RD.
- `end_mem` and `data_in_mem` hold their last values outside access states.
- `reg_saida_mem` changes only on LOAD capture or LOADI.
- `enable`=0 in any state holds every register and output, including `rd`/`we`, so a strobe is stretched. The latency counter does not advance.
- Reset values: `rd`=0, `we`=0, `done`=0, `instr_ready`=1 (IDLE), `end_mem`=0, `data_in_mem`=0, `reg_saida_mem`=0, counter 0.
- Reset mid-operation aborts the access immediately (strobes drop asynchronously) and returns the unit to IDLE. It does not produce a `done`.

## Timing
- STORE: `we` high in T+1; `done` in T+2; `instr_ready` high in T+3.
- LOAD: `rd` high in T+1 only. `data_out_mem` is sampled at the end of cycle T+1+MEM_LAT. `reg_saida_mem` is valid and `done` is high in T+2+MEM_LAT.
- LOADI and NOP: `done` in T+1, with `reg_saida_mem` already updated for LOADI.
- `instr_ready` is 0 from T+1 until the cycle after `done`. There is at most one instruction in flight.
- `instr_valid` while not ready is ignored. The source must hold it until accepted.
- Each cycle with `enable`=0 adds exactly one cycle to every latency above.

## Structure
- The shared package `proc_pkg` holds:
  - opcode constants OP_STORE, OP_LOAD, OP_LOADI;
  - the FSM state enum `uc_state_t`;
  - the default widths.
- The ULA and the RAM models use the same package.
- No sub-module is needed. The latency counter is inline; it is a 4-bit down-counter.

## Test plan
- Reset, then STORE with operand 4'h5 and `reg_saida_ula`=8'hA7 → `we`=1 in T+1 with `end_mem`=5 and `data_in_mem`=A7; `done` in T+2; `rd` stays 0.
- LOAD with operand 4'h3, RAM[3]=8'h3C, MEM_LAT=1 and then 3 → `rd` single-cycle in T+1; `reg_saida_mem`=3C and `done` in T+3 and T+5 respectively.
- LOADI with operand 4'h9 → `reg_saida_mem`=8'h09 and `done` in T+1; no `rd`/`we`.
- `enable` pulled low for 2 cycles during LOAD_WAIT (MEM_LAT=3) → `done` delayed to T+7; the value is still correct. `instr_valid` during the busy period is not accepted.
- `reset_n` asserted during STORE → `we` drops without a clock edge; `instr_ready`=1; no `done`; all outputs at their reset values.
- NOP opcode 4'b0010 followed back-to-back by STORE → `done` in T+1; STORE accepted in T+2; no spurious strobes.
